// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and the default datapath width.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration on the {upper, lower} accumulator: shift-add for
// multiply, restoring shift-subtract for divide.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_in,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_sub;

  // rem_sh carries one extra bit so a remainder above 2^(WIDTH-1) still compares correctly
  always_comb begin
    sum       = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opnd} : '0);
    rem_sh    = acc_in[2*WIDTH-1:WIDTH-1];
    no_borrow = (rem_sh >= {1'b0, opnd});
    rem_sub   = rem_sh[WIDTH-1:0] - opnd;
    if (is_div) begin
      acc_out = {(no_borrow ? rem_sub : rem_sh[WIDTH-1:0]), acc_in[WIDTH-2:0], no_borrow};
    end else begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Signed operations run on magnitudes and apply the sign fixup in a final cycle.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e         state_q, state_d;
  mdu_op_e            op_q, op_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               is_div;
  logic [2*WIDTH-1:0] step_acc;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_div = (op_q == MDU_DIV) || (op_q == MDU_DIVU);

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div),
    .acc_in  (acc_q),
    .opnd    (opnd_q),
    .acc_out (step_acc)
  );

  // op[0]=0 selects the signed variants, op[1]=1 selects divide
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    count_d   = count_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = mdu_op_e'(op);
          a_raw_d   = a;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = op[1] & a_neg;
          dbz_d     = op[1] && (b == '0);
          count_d   = CW'(WIDTH - 1);
          busy_d    = 1'b1;
          state_d   = S_RUN;
          if (op[1]) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      S_RUN: begin
        acc_d = step_acc;
        if (count_q == '0) begin
          state_d = S_FIX;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      S_FIX: begin
        // Divide by zero reports the untouched dividend rather than the fixed-up remainder
        if (!is_div) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (dbz_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= MDU_MULT;
      count_q   <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: expected HI/LO pairs are queued when an
// operation is launched and compared when the unit reports completion.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference results from plain wide arithmetic, returned as {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin
        q = sx * sy;
        res = q;
      end
      2'b01: res = {32'b0, x} * {32'b0, y};
      2'b10: begin
        if (y == 0) begin
          res = {x, 32'hFFFFFFFF};
        end else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 0) res = {x, 32'hFFFFFFFF};
        else res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  // Launch one operation (assumes we sit just after a rising edge) and check its result
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp_res, input int inject_at, input logic with_mthi);
    int cyc;
    logic saw_bad;
    logic [63:0] want;
    sb.push_back(exp_res);
    op = o; a = x; b = y; start = 1'b1;
    mthi = with_mthi;
    wdata = with_mthi ? 32'hDEADBEEF : 32'h0;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    a = $urandom; b = $urandom;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("[TB] FAIL start_busy: got %b expected 1", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("[TB] FAIL done_width: got %b expected 0", done);
    end
    cyc = 0;
    saw_bad = 1'b0;
    while (busy === 1'b1 && cyc < 100) begin
      if (cyc == inject_at) begin
        start = 1'b1; op = 2'b10; a = 32'h00001234; b = 32'h00000003;
        mthi = 1'b1; wdata = 32'h12345678;
      end
      @(posedge clk); #1;
      cyc++;
      start = 1'b0; mthi = 1'b0;
      if (hi === 32'hDEADBEEF || hi === 32'h12345678) saw_bad = 1'b1;
    end
    checks++;
    if (cyc != 33) begin
      errors++; $display("[TB] FAIL latency: got %0d cycles expected 33", cyc);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("[TB] FAIL done_pulse: got %b expected 1", done);
    end
    checks++;
    if (saw_bad !== 1'b0) begin
      errors++; $display("[TB] FAIL hi_leak: got %b expected 0", saw_bad);
    end
    want = sb.pop_front();
    checks++;
    if (hi !== want[63:32]) begin
      errors++; $display("[TB] FAIL hi op=%0d a=%h b=%h: got %h expected %h", o, x, y, hi, want[63:32]);
    end
    checks++;
    if (lo !== want[31:0]) begin
      errors++; $display("[TB] FAIL lo op=%0d a=%h b=%h: got %h expected %h", o, x, y, lo, want[31:0]);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
    checks++;
    if (lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multu_max;
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001}, -1, 1'b0);
  endtask

  task automatic test_signed;
    do_op(2'b00, 32'hFFFFFFFD, 32'h00000005, {32'hFFFFFFFF, 32'hFFFFFFF1}, -1, 1'b0);
    do_op(2'b10, 32'hFFFFFFF9, 32'h00000002, {32'hFFFFFFFF, 32'hFFFFFFFD}, -1, 1'b0);
  endtask

  task automatic test_div_corner;
    do_op(2'b11, 32'd100, 32'd0, {32'h00000064, 32'hFFFFFFFF}, -1, 1'b0);
    do_op(2'b10, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF}, -1, 1'b0);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, -1, 1'b0);
  endtask

  task automatic test_busy_ignore;
    do_op(2'b01, 32'd6, 32'd7, {32'h0, 32'd42}, 10, 1'b0);
  endtask

  task automatic test_move;
    @(posedge clk); #1;
    mtlo = 1'b1; wdata = 32'hCAFEBABE;
    @(posedge clk); #1;
    mtlo = 1'b0;
    checks++;
    if (lo !== 32'hCAFEBABE) begin errors++; $display("[TB] FAIL mtlo_lo: got %h expected cafebabe", lo); end
    checks++;
    if (hi !== 32'h0) begin errors++; $display("[TB] FAIL mtlo_hi: got %h expected 0", hi); end
    mthi = 1'b1; wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    mthi = 1'b0;
    checks++;
    if (hi !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL mthi_hi: got %h expected 0badf00d", hi); end
    checks++;
    if (lo !== 32'hCAFEBABE) begin errors++; $display("[TB] FAIL mthi_lo: got %h expected cafebabe", lo); end
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if ({hi, lo} !== {32'h55AA55AA, 32'h55AA55AA}) begin
      errors++; $display("[TB] FAIL mt_both: got %h_%h expected 55aa55aa_55aa55aa", hi, lo);
    end
  endtask

  task automatic test_async_reset;
    op = 2'b01; a = 32'd6; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL areset_busy: got %b expected 0", busy); end
    checks++;
    if ({hi, lo} !== 64'h0) begin errors++; $display("[TB] FAIL areset_hilo: got %h_%h expected 0", hi, lo); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL areset_done: got %b expected 0", done); end
    reset = 1'b1;
    do_op(2'b01, 32'd6, 32'd7, {32'h0, 32'd42}, -1, 1'b0);
  endtask

  task automatic test_start_with_mthi;
    do_op(2'b01, 32'd2, 32'd3, {32'h0, 32'd6}, -1, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic [1:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = (i < 5) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 3 == 0) x = 32'($urandom_range(0, 500)) - 32'd250;
      if (y == 0) y = 32'd1;
      if (o == 2'b10 && x == 32'h80000000 && y == 32'hFFFFFFFF) y = 32'd1;
      do_op(o, x, y, model(o, x, y), -1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_div_corner();
    test_busy_ignore();
    test_move();
    test_async_reset();
    test_start_with_mthi();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core.
- Sits beside the ALU in the datapath. Operands come from the register-file read ports; results return to the writeback mux via mfhi/mflo.
- The controller stalls the PC while busy is high.
- Implements mult, multu, div, divu, mthi and mtlo using an iterative radix-2 algorithm: shift-add for multiply, restoring for divide.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  launch operation; sampled only in IDLE
op  input  2  00 mult, 01 multu, 10 div, 11 divu
a  input  WIDTH  rs operand (multiplicand / dividend)
b  input  WIDTH  rt operand (multiplier / divisor)
mthi  input  1  write wdata to HI
mtlo  input  1  write wdata to LO
wdata  input  WIDTH  data for mthi/mtlo
busy  output  1  operation in progress; core must stall
done  output  1  one-cycle pulse when HI/LO updated by an operation
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0. An operation in flight is aborted with no partial result written.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - start=1 at edge E0 latches op, a and b, and forms magnitudes |a| and |b| for signed ops (operands are used as-is for unsigned ops).
  - Sets counter=WIDTH-1 and moves to RUN.
  - busy=1 from E0 onward.
- RUN: one iteration per cycle for WIDTH cycles (edges E1..E32 at WIDTH=32); counter decrements and the state leaves for FIX when counter==0.
  - Multiply: 2*WIDTH product accumulator; add multiplicand if multiplier LSB=1, then shift right.
  - Divide: shift remainder:quotient left; subtract divisor if no borrow and set quotient bit, else restore.
- FIX (edge E33):
  - Mult: negate the 2*WIDTH product if sign(a)!=sign(b), signed op only.
  - Div: negate the quotient if signs differ; the remainder takes the sign of the dividend.
  - Write hi/lo, set done=1 for exactly one cycle, clear busy, return to IDLE.
- Total: busy high for WIDTH+1 cycles (33). Results are visible on hi/lo in the cycle busy first reads 0.
- Divide by zero (b==0, div or divu): lo=all ones, hi=a (unmodified dividend). The iteration still runs for the full latency so timing is identical.
- div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
- start while busy: ignored; the in-flight operation continues with its latched operands.
- mthi/mtlo:
  - In IDLE they write on the same edge; mthi and mtlo together write both registers.
  - While busy they are ignored.
  - If asserted with start in IDLE, start wins and the mthi/mtlo write is dropped.
- hi/lo hold their values between operations. Operand inputs are don't-care except at the start edge.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU
  - state encoding S_IDLE, S_RUN, S_FIX
  - WIDTH default constant
- One sub-module, mdu_step: a combinational single iteration (shift-add or restore-subtract) selected by an is_div flag. The top level holds the FSM, counter, sign fixup and HI/LO registers.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF -> after 33 cycles busy=0, done pulse once, hi=0xFFFFFFFE, lo=0x00000001.
- mult a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then div a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=100 b=0 -> lo=0xFFFFFFFF, hi=0x00000064, latency still 33 cycles. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start multu 6*7, then at cycle 10 pulse start (op=div, other operands) and mthi wdata=0x12345678 -> both ignored; final hi=0, lo=42. In IDLE, mtlo wdata=0xCAFEBABE -> lo=0xCAFEBABE next cycle, hi unchanged.
- Start multu 6*7, drive reset=0 at cycle 15 -> busy=0, hi=lo=0 immediately (asynchronous). Release reset, rerun 6*7 -> lo=42 after 33 cycles.
- start and mthi together in IDLE (multu 2*3, wdata=0xDEADBEEF) -> hi=0, lo=6; 0xDEADBEEF never appears on hi.
